// File: rtl/sample_acc_pkg.sv
// Shared constants and address helpers for the sample accumulator.
// Byte addresses from the trigger FSM map to one sample slot per 32-bit word.
package sample_acc_pkg;

  localparam int ACC_W_DEF  = 32;
  localparam int ADDR_W_DEF = 10;
  localparam int ADC_W      = 14;

  // Word index of a byte address; callers truncate to their own depth.
  function automatic logic [31:0] sample_index(input logic [31:0] byte_addr);
    return byte_addr >> 2;
  endfunction

  // Legal when word aligned and inside a 2**addr_w sample window.
  function automatic logic addr_legal(input logic [31:0] byte_addr, input int addr_w);
    return (byte_addr[1:0] == 2'b00) && ((byte_addr >> (addr_w + 2)) == 32'd0);
  endfunction

endpackage

// File: rtl/sdp_ram.sv
// Simple dual-port RAM: one write port, one registered read port.
// A read of the address being written returns the old contents.
module sdp_ram #(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/sample_accumulator.sv
// Point-by-point accumulator for the two-channel sample stream, with a host
// read port that is serviced only while the accumulation pipeline is idle.
module sample_accumulator
  import sample_acc_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int ACC_W  = ACC_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADC_W-1:0]  in_A,
  input  logic [ADC_W-1:0]  in_B,
  input  logic              in_we,
  input  logic [31:0]       in_addr,
  input  logic              clear,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              rd_valid,
  output logic              rd_err,
  output logic [ACC_W-1:0]  rd_data_A,
  output logic [ACC_W-1:0]  rd_data_B,
  output logic              busy,
  output logic [23:0]       pass_cnt,
  output logic              acc_ovf,
  output logic              addr_err
);

  logic [ADDR_W-1:0]        in_idx;
  logic                     in_ok;
  logic [1:0][ADC_W-1:0]    in_raw;
  logic                     we_prev_reg;
  logic                     s1_valid_reg, s1_first_reg;
  logic                     s2_valid_reg, s2_first_reg, s2_fwd_reg;
  logic [ADDR_W-1:0]        s1_idx_reg, s2_idx_reg;
  logic                     busy_reg, h1_ok_reg, h1_err_reg;
  logic                     rd_valid_reg, rd_err_reg;
  logic [23:0]              pass_cnt_reg, pass_cnt_next;
  logic                     acc_ovf_reg, acc_ovf_next;
  logic                     addr_err_reg, addr_err_next;
  logic [1:0]               ovf_ch;
  logic [ADDR_W-1:0]        ram_raddr;
  logic [2*ACC_W-1:0]       ram_rdata, ram_wdata;

  assign in_idx = ADDR_W'(sample_index(in_addr));
  assign in_ok  = addr_legal(in_addr, ADDR_W);
  assign in_raw = {in_B, in_A};

  // The pipeline owns the read port whenever anything may be in flight.
  assign ram_raddr = busy_reg ? s1_idx_reg : rd_addr;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_ch
      logic [ACC_W-1:0] in_sext, mem_val, base, sum;
      logic [ACC_W-1:0] s1_val_reg, s2_val_reg, fwd_reg, rd_data_reg;

      assign in_sext = {{(ACC_W-ADC_W){in_raw[gi][ADC_W-1]}}, in_raw[gi]};
      assign mem_val = ram_rdata[gi*ACC_W +: ACC_W];
      // Forwarded sum covers the write the memory read could not yet see.
      assign base    = s2_first_reg ? '0 : (s2_fwd_reg ? fwd_reg : mem_val);
      assign sum     = base + s2_val_reg;
      assign ovf_ch[gi] = s2_valid_reg && (base[ACC_W-1] == s2_val_reg[ACC_W-1])
                          && (sum[ACC_W-1] != base[ACC_W-1]);
      assign ram_wdata[gi*ACC_W +: ACC_W] = sum;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          s1_val_reg  <= '0;
          s2_val_reg  <= '0;
          fwd_reg     <= '0;
          rd_data_reg <= '0;
        end else begin
          s1_val_reg <= in_sext;
          s2_val_reg <= s1_val_reg;
          fwd_reg    <= sum;
          if (h1_ok_reg) rd_data_reg <= mem_val;
        end
      end
    end
  endgenerate

  always_comb begin
    pass_cnt_next = pass_cnt_reg;
    acc_ovf_next  = acc_ovf_reg | (|ovf_ch);
    addr_err_next = addr_err_reg;
    if (we_prev_reg && !in_we) pass_cnt_next = pass_cnt_reg + 24'd1;
    if (clear) begin
      pass_cnt_next = '0;
      acc_ovf_next  = 1'b0;
      addr_err_next = 1'b0;
    end
    // A bad beat in the clear cycle belongs to the new acquisition.
    if (in_we && !in_ok) addr_err_next = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_prev_reg  <= 1'b0;
      s1_valid_reg <= 1'b0;
      s1_first_reg <= 1'b0;
      s1_idx_reg   <= '0;
      s2_valid_reg <= 1'b0;
      s2_first_reg <= 1'b0;
      s2_fwd_reg   <= 1'b0;
      s2_idx_reg   <= '0;
      busy_reg     <= 1'b0;
      h1_ok_reg    <= 1'b0;
      h1_err_reg   <= 1'b0;
      rd_valid_reg <= 1'b0;
      rd_err_reg   <= 1'b0;
      pass_cnt_reg <= '0;
      acc_ovf_reg  <= 1'b0;
      addr_err_reg <= 1'b0;
    end else begin
      we_prev_reg  <= in_we;
      s1_valid_reg <= in_we && in_ok;
      s1_first_reg <= clear || (pass_cnt_reg == 24'd0);
      s1_idx_reg   <= in_idx;
      s2_valid_reg <= s1_valid_reg;
      s2_first_reg <= s1_first_reg;
      s2_fwd_reg   <= s1_valid_reg && s2_valid_reg && (s1_idx_reg == s2_idx_reg);
      s2_idx_reg   <= s1_idx_reg;
      busy_reg     <= in_we || s1_valid_reg;
      h1_ok_reg    <= rd_en && !busy_reg;
      h1_err_reg   <= rd_en && busy_reg;
      rd_valid_reg <= h1_ok_reg || h1_err_reg;
      rd_err_reg   <= h1_err_reg;
      pass_cnt_reg <= pass_cnt_next;
      acc_ovf_reg  <= acc_ovf_next;
      addr_err_reg <= addr_err_next;
    end
  end

  sdp_ram #(
    .DATA_W(2*ACC_W),
    .ADDR_W(ADDR_W)
  ) u_ram (
    .clk  (clk),
    .we   (s2_valid_reg),
    .waddr(s2_idx_reg),
    .wdata(ram_wdata),
    .raddr(ram_raddr),
    .rdata(ram_rdata)
  );

  assign rd_valid  = rd_valid_reg;
  assign rd_err    = rd_err_reg;
  assign rd_data_A = g_ch[0].rd_data_reg;
  assign rd_data_B = g_ch[1].rd_data_reg;
  assign busy      = busy_reg;
  assign pass_cnt  = pass_cnt_reg;
  assign acc_ovf   = acc_ovf_reg;
  assign addr_err  = addr_err_reg;

endmodule

// File: tb/tb_sample_accumulator.sv
// Scoreboard bench for sample_accumulator: reads push expected responses,
// a monitor pops them on rd_valid; a narrow instance exercises overflow.
module tb_sample_accumulator;

  logic        clk = 1'b0;
  logic        rst_n, in_we, clear, rd_en;
  logic [13:0] in_A, in_B;
  logic [31:0] in_addr;
  logic [9:0]  rd_addr;

  logic        rd_valid, rd_err, busy, acc_ovf, addr_err;
  logic [31:0] rd_data_A, rd_data_B;
  logic [23:0] pass_cnt;

  logic        s_rd_valid, s_rd_err, s_busy, s_acc_ovf, s_addr_err;
  logic [15:0] s_rd_data_A, s_rd_data_B;
  logic [23:0] s_pass_cnt;

  sample_accumulator #(.ADDR_W(10), .ACC_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .in_A(in_A), .in_B(in_B), .in_we(in_we),
    .in_addr(in_addr), .clear(clear), .rd_en(rd_en), .rd_addr(rd_addr),
    .rd_valid(rd_valid), .rd_err(rd_err), .rd_data_A(rd_data_A),
    .rd_data_B(rd_data_B), .busy(busy), .pass_cnt(pass_cnt),
    .acc_ovf(acc_ovf), .addr_err(addr_err)
  );

  // 16-bit accumulators reach signed overflow after five passes of 8191.
  sample_accumulator #(.ADDR_W(10), .ACC_W(16)) dut_narrow (
    .clk(clk), .rst_n(rst_n), .in_A(in_A), .in_B(in_B), .in_we(in_we),
    .in_addr(in_addr), .clear(clear), .rd_en(rd_en), .rd_addr(rd_addr),
    .rd_valid(s_rd_valid), .rd_err(s_rd_err), .rd_data_A(s_rd_data_A),
    .rd_data_B(s_rd_data_B), .busy(s_busy), .pass_cnt(s_pass_cnt),
    .acc_ovf(s_acc_ovf), .addr_err(s_addr_err)
  );

  always #5 clk = ~clk;

  typedef struct { bit err; int a; int b; } rsp_t;
  rsp_t exp_q[$];
  rsp_t mon_r;
  int   checks = 0;
  int   failures = 0;
  int   last_a = 0;
  int   last_b = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic [31:0] addr, input int a, input int b);
    in_we = 1'b1; in_addr = addr; in_A = 14'(a); in_B = 14'(b);
    tick();
    in_we = 1'b0;
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 20) begin
      tick();
      n++;
    end
    chk("busy_drain", busy, 0);
  endtask

  task automatic rd_ok(input int idx, input int ea, input int eb);
    rd_en = 1'b1; rd_addr = 10'(idx);
    exp_q.push_back('{err: 1'b0, a: ea, b: eb});
    last_a = ea; last_b = eb;
    tick();
    rd_en = 1'b0;
  endtask

  always @(negedge clk) begin
    if (rst_n && rd_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_rd_valid: got rd_valid=1 expected none pending");
      end else begin
        mon_r = exp_q.pop_front();
        chk("rd_err", rd_err, mon_r.err);
        chk("rd_data_A", $signed(rd_data_A), mon_r.a);
        chk("rd_data_B", $signed(rd_data_B), mon_r.b);
      end
    end
  end

  initial begin
    rst_n = 1'b0; in_we = 1'b0; clear = 1'b0; rd_en = 1'b0;
    in_addr = '0; in_A = '0; in_B = '0; rd_addr = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_rd_valid", rd_valid, 0);
    chk("rst_rd_err", rd_err, 0);
    chk("rst_rd_data_A", rd_data_A, 0);
    chk("rst_rd_data_B", rd_data_B, 0);
    chk("rst_busy", busy, 0);
    chk("rst_pass_cnt", pass_cnt, 0);
    chk("rst_acc_ovf", acc_ovf, 0);
    chk("rst_addr_err", addr_err, 0);
    rst_n = 1'b1;
    tick();

    // single first pass
    pulse_clear();
    for (int i = 0; i < 4; i++) beat(32'(4*i), i+1, -(i+1));
    wait_idle();
    chk("pass_cnt_1", pass_cnt, 1);
    for (int i = 0; i < 4; i++) rd_ok(i, i+1, -(i+1));
    repeat (3) tick();

    // three more passes with 7-cycle gaps
    for (int p = 0; p < 3; p++) begin
      repeat (7) tick();
      for (int i = 0; i < 4; i++) beat(32'(4*i), i+1, -(i+1));
    end
    wait_idle();
    chk("pass_cnt_4", pass_cnt, 4);
    for (int i = 0; i < 4; i++) rd_ok(i, 4*(i+1), -4*(i+1));
    repeat (3) tick();

    // back-to-back same index needs forwarding
    pulse_clear();
    beat(32'd0, 0, 0);
    tick();
    beat(32'd0, 5, -3);
    beat(32'd0, 5, -3);
    wait_idle();
    chk("pass_cnt_fwd", pass_cnt, 2);
    rd_ok(0, 10, -6);
    repeat (3) tick();

    // illegal addresses are dropped
    chk("addr_err_before", addr_err, 0);
    beat(32'h2, 100, 100);
    beat(32'd4096, 100, 100);
    wait_idle();
    chk("addr_err_set", addr_err, 1);
    chk("pass_cnt_bad", pass_cnt, 3);
    rd_ok(0, 10, -6);
    repeat (3) tick();
    pulse_clear();
    chk("addr_err_cleared", addr_err, 0);
    chk("pass_cnt_cleared", pass_cnt, 0);

    // overflow on the narrow instance
    for (int p = 0; p < 4; p++) begin
      beat(32'd0, 8191, 0);
      tick();
    end
    wait_idle();
    chk("narrow_pass_cnt", s_pass_cnt, 4);
    chk("narrow_ovf_pre", s_acc_ovf, 0);
    beat(32'd0, 8191, 0);
    wait_idle();
    chk("narrow_ovf_set", s_acc_ovf, 1);
    chk("wide_ovf_clear", acc_ovf, 0);
    rd_ok(0, 40955, 0);
    repeat (3) tick();
    pulse_clear();
    chk("narrow_ovf_cleared", s_acc_ovf, 0);

    // host read during a pass is rejected and data holds
    beat(32'd0, 1, -1);
    beat(32'd4, 2, -2);
    rd_en = 1'b1; rd_addr = 10'd1;
    exp_q.push_back('{err: 1'b1, a: last_a, b: last_b});
    beat(32'd8, 3, -3);
    rd_en = 1'b0;
    beat(32'd12, 4, -4);
    wait_idle();
    chk("pass_cnt_rej", pass_cnt, 1);
    rd_ok(2, 3, -3);
    repeat (3) tick();

    // reset mid-pass
    beat(32'd0, 7, 7);
    beat(32'd4, 7, 7);
    in_we = 1'b1; in_addr = 32'd8;
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_pass_cnt", pass_cnt, 0);
    chk("mid_rst_rd_valid", rd_valid, 0);
    chk("mid_rst_rd_data_A", rd_data_A, 0);
    chk("mid_rst_rd_data_B", rd_data_B, 0);
    last_a = 0; last_b = 0;
    in_we = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    pulse_clear();
    beat(32'd0, 10, -10);
    beat(32'd4, 20, -20);
    beat(32'd8, 30, -30);
    wait_idle();
    chk("pass_cnt_after_rst", pass_cnt, 1);
    rd_ok(0, 10, -10);
    rd_ok(1, 20, -20);
    rd_ok(2, 30, -30);
    repeat (3) tick();

    // beat coinciding with clear is first pass
    clear = 1'b1;
    beat(32'd0, 50, 0);
    clear = 1'b0;
    wait_idle();
    rd_ok(0, 50, 0);
    repeat (4) tick();

    chk("queue_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
